bpu_gshare: RTL and testbench
=============================

Name: bpu_gshare

Overview:
- Parametrised successor to the single-table branch prediction buffer.
- Sits beside fetch: predicts next PC in F from a direct-mapped BTB plus a 2-bit saturating-counter pattern table, indexed bimodally or gshare-style.
- Carries each prediction into D, compares it with decode's resolved outcome, and raises a one-cycle miss with the corrective PC.
- Keeps wrap-around branch/miss statistics counters.

Parameters:
- PHT_ENTRIES, 64, pattern-table depth; power of 2, ≥4.
- BTB_ENTRIES, 16, target-buffer depth; power of 2, ≥2.
- GHR_WIDTH, 6, global history bits; 1..log2(PHT_ENTRIES).
- MODE, 1, 0 = bimodal (PC index), 1 = gshare (PC xor GHR).
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, active-low, asynchronous.
- en_i  in  1  pipeline advance (~stall_f); low holds the F→D register and GHR.
- flush_d_i  in  1  kills the D-stage prediction record; no update, no miss that cycle.
- pc_f_i  in  32  fetch PC.
- predict_pc_o  out  32  next fetch PC: BTB target if predicted taken, else pc_f_i+4.
- predict_taken_o  out  1  F-stage taken prediction.
- branch_d_i  in  1  instruction in D is a conditional branch.
- real_taken_i  in  1  resolved direction in D.
- real_target_i  in  32  resolved branch target in D.
- miss_o  out  1  D-stage misprediction.
- correct_pc_o  out  32  redirect PC when miss_o: real_target_i if taken, else pc_d+4.
- branch_cnt_o  out  CNT_WIDTH  resolved branches.
- miss_cnt_o  out  CNT_WIDTH  mispredictions.

Behaviour:
- Definitions: PI = log2(PHT_ENTRIES); BI = log2(BTB_ENTRIES).
- PHT index: pc[PI+1:2], XORed with zero-extended GHR when MODE=1.
- BTB index: pc[BI+1:2]. Tag: pc[31:BI+2].
- F-stage lookup is combinational. predict_taken_o = BTB valid & tag match & PHT[idx][1].
- F→D record, loaded on the clock edge when en_i=1: pc_f_i, pht_idx, predict_taken_o, predicted target.
  - flush_d_i=1 with en_i=1 loads an invalid record.
  - en_i=0 holds the record.
- D-stage check, gated by valid record & branch_d_i & ~flush_d_i:
  - miss_o = (pred_taken ≠ real_taken_i) | (real_taken_i & pred_target ≠ real_target_i).
  - Combinational; asserted for one cycle per D instruction.
  - miss_o is 0 for non-branches, including when the record predicted taken. BTB only allocates branches, so stale aliasing is tolerated.
- Update at clock edge, same gating, and only when en_i=1 (a stalled D updates once, when it advances):
  - PHT[saved idx]: saturating +1 if taken, −1 if not; 3 and 0 hold.
  - GHR shifts left, real_taken_i enters the LSB. The GHR is non-speculative (resolved outcomes only).
  - If taken: BTB[idx(pc_d)] ← {valid, tag, real_target_i}. Not-taken never invalidates.
  - branch_cnt_o +1. miss_cnt_o +1 if miss_o. Both wrap at 2^CNT_WIDTH.
- Same-cycle F lookup and D update of one entry: lookup sees the pre-update value.
- Reset, async: all PHT entries = 2'b01 (weakly not-taken), BTB valid = 0, GHR = 0, record invalid, counters = 0.
  - Resulting outputs: miss_o = 0, predict_taken_o = 0, predict_pc_o = pc_f_i+4.
  - Reset mid-operation discards all history immediately.
- Latency: prediction 0 cycles (F); resolution and redirect 1 cycle later (D); table writes are visible to the next lookup.

Test Plan:
- Reset, pc_f_i=0x100 → predict_pc_o=0x104, predict_taken_o=0, miss_o=0, counters 0.
- Branch at 0x200 taken to 0x180, twice (MODE=0) → 1st: miss_o=1, correct_pc_o=0x180. PHT 01→10, BTB filled. 2nd fetch of 0x200: predict_pc_o=0x180, no miss. branch_cnt=2, miss_cnt=1.
- Counter saturation: 5 taken resolutions at 0x200, then 1 not-taken → PHT stays 11, then 10. Next fetch still predicts taken.
- Stale target: BTB holds 0x200→0x180; branch resolves taken to 0x1C0 → miss_o=1, correct_pc_o=0x1C0, BTB target updated.
- flush_d_i=1 with branch_d_i=1 → miss_o=0, no PHT/GHR/counter change. en_i=0 for 3 cycles → exactly one update.
- MODE=1, alternating T/N loop branch at 0x300, 20 iterations → after warm-up (≤8 iterations) miss_o stays 0. miss_cnt_o ≤ 8.

Source files
------------

// File: rtl/bpu_gshare_if.sv
// Fetch/decode-side signal bundle for the gshare branch predictor.
// The master is the pipeline (drives PCs and resolved outcomes); the slave is the predictor.
interface bpu_gshare_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 en_i;
    logic                 flush_d_i;
    logic [31:0]          pc_f_i;
    logic [31:0]          predict_pc_o;
    logic                 predict_taken_o;
    logic                 branch_d_i;
    logic                 real_taken_i;
    logic [31:0]          real_target_i;
    logic                 miss_o;
    logic [31:0]          correct_pc_o;
    logic [CNT_WIDTH-1:0] branch_cnt_o;
    logic [CNT_WIDTH-1:0] miss_cnt_o;

    modport master (
        output en_i, flush_d_i, pc_f_i, branch_d_i, real_taken_i, real_target_i,
        input  predict_pc_o, predict_taken_o, miss_o, correct_pc_o, branch_cnt_o, miss_cnt_o
    );

    modport slave (
        input  en_i, flush_d_i, pc_f_i, branch_d_i, real_taken_i, real_target_i,
        output predict_pc_o, predict_taken_o, miss_o, correct_pc_o, branch_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/bpu_gshare.sv
// Purpose: direct-mapped BTB + 2-bit PHT next-PC predictor (bimodal or gshare) with D-stage check.
// Latency: prediction combinational in F; miss/correct_pc combinational in D, one cycle later.
// Backpressure: en_i low freezes the F->D record, tables, history and counters.
module bpu_gshare #(
    parameter int PHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_WIDTH   = 6,
    parameter int MODE        = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bpu_gshare_if.slave bus
);
    localparam int PI = $clog2(PHT_ENTRIES);
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - BI;

    typedef struct packed {
        logic          vld;
        logic [31:0]   pc;
        logic [PI-1:0] pidx;
        logic          taken;
        logic [31:0]   target;
    } rec_t;

    logic [1:0]             pht     [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TW-1:0]          btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];
    logic [GHR_WIDTH-1:0]   ghr;
    rec_t                   rec;
    logic [CNT_WIDTH-1:0]   branch_cnt;
    logic [CNT_WIDTH-1:0]   miss_cnt;

    logic [PI-1:0] ghr_ext;
    logic [PI-1:0] f_pidx;
    logic [BI-1:0] f_bidx;
    logic [BI-1:0] d_bidx;
    logic          f_hit;
    logic          f_taken;
    logic [31:0]   f_ppc;
    logic          d_chk;
    logic          d_miss;
    logic          d_upd;
    logic [31:0]   d_cpc;
    logic [1:0]    pht_cur;
    logic [1:0]    pht_nxt;

    // F-stage lookup reads pre-update table state, so a same-cycle D write is not forwarded.
    always_comb begin
        ghr_ext                 = '0;
        ghr_ext[GHR_WIDTH-1:0]  = ghr;
        f_pidx                  = bus.pc_f_i[PI+1:2];
        if (MODE != 0) begin
            f_pidx = f_pidx ^ ghr_ext;
        end
        f_bidx  = bus.pc_f_i[BI+1:2];
        f_hit   = btb_vld[f_bidx] && (btb_tag[f_bidx] == bus.pc_f_i[31:BI+2]);
        f_taken = f_hit && pht[f_pidx][1];
        f_ppc   = f_taken ? btb_tgt[f_bidx] : bus.pc_f_i + 32'd4;
    end

    always_comb begin
        d_chk  = rec.vld && bus.branch_d_i && !bus.flush_d_i;
        d_miss = d_chk && ((rec.taken != bus.real_taken_i) ||
                           (bus.real_taken_i && (rec.target != bus.real_target_i)));
        d_upd  = d_chk && bus.en_i;
        d_cpc  = bus.real_taken_i ? bus.real_target_i : rec.pc + 32'd4;
        d_bidx = rec.pc[BI+1:2];
        pht_cur = pht[rec.pidx];
        pht_nxt = pht_cur;
        if (bus.real_taken_i) begin
            if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'd1;
        end else begin
            if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rec <= '0;
        end else if (bus.en_i) begin
            if (bus.flush_d_i) begin
                rec <= '0;
            end else begin
                rec <= '{vld: 1'b1, pc: bus.pc_f_i, pidx: f_pidx,
                         taken: f_taken, target: f_ppc};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (d_upd) begin
            pht[rec.pidx] <= pht_nxt;
        end
    end

    // History holds resolved outcomes only; the oldest bit falls off the top.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ghr <= '0;
        end else if (d_upd) begin
            ghr <= GHR_WIDTH'({ghr, bus.real_taken_i});
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            btb_vld <= '0;
        end else if (d_upd && bus.real_taken_i) begin
            btb_vld[d_bidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (d_upd && bus.real_taken_i) begin
            btb_tag[d_bidx] <= rec.pc[31:BI+2];
            btb_tgt[d_bidx] <= bus.real_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (d_upd) begin
            branch_cnt <= branch_cnt + 1'b1;
            if (d_miss) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign bus.predict_pc_o    = f_ppc;
    assign bus.predict_taken_o = f_taken;
    assign bus.miss_o          = d_miss;
    assign bus.correct_pc_o    = d_cpc;
    assign bus.branch_cnt_o    = branch_cnt;
    assign bus.miss_cnt_o      = miss_cnt;
endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: a bimodal and a gshare instance share stimulus; hand vectors plus a reference model.
module tb_bpu_gshare;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    bpu_gshare_if #(.CNT_WIDTH(32)) b0 ();
    bpu_gshare_if #(.CNT_WIDTH(32)) b1 ();

    bpu_gshare #(.PHT_ENTRIES(64), .BTB_ENTRIES(16), .GHR_WIDTH(6), .MODE(0), .CNT_WIDTH(32))
        u_bim (.clk_i(clk_i), .rst_i(rst_i), .bus(b0));
    bpu_gshare #(.PHT_ENTRIES(64), .BTB_ENTRIES(16), .GHR_WIDTH(6), .MODE(1), .CNT_WIDTH(32))
        u_gsh (.clk_i(clk_i), .rst_i(rst_i), .bus(b1));

    int vectors = 0;
    int miscompares = 0;

    bit          en_v, fl_v, br_v, rt_v;
    logic [31:0] pc_v, rtg_v;

    // Reference model state, index 0 = bimodal, 1 = gshare.
    int unsigned m_pht  [2][64];
    bit          m_bv   [2][16];
    logic [31:0] m_btag [2][16];
    logic [31:0] m_btgt [2][16];
    int unsigned m_ghr  [2];
    bit          m_rv   [2];
    logic [31:0] m_rpc  [2];
    logic [31:0] m_rtg  [2];
    int unsigned m_ridx [2];
    bit          m_rtk  [2];
    logic [31:0] m_bc   [2];
    logic [31:0] m_mc   [2];

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit e, bit f, logic [31:0] p, bit b, bit t, logic [31:0] g);
        en_v = e; fl_v = f; pc_v = p; br_v = b; rt_v = t; rtg_v = g;
        b0.en_i = e; b0.flush_d_i = f; b0.pc_f_i = p;
        b0.branch_d_i = b; b0.real_taken_i = t; b0.real_target_i = g;
        b1.en_i = e; b1.flush_d_i = f; b1.pc_f_i = p;
        b1.branch_d_i = b; b1.real_taken_i = t; b1.real_target_i = g;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) m_pht[m][i] = 1;
            for (int i = 0; i < 16; i++) m_bv[m][i] = 0;
            m_ghr[m] = 0; m_rv[m] = 0; m_bc[m] = 0; m_mc[m] = 0;
        end
    endtask

    function automatic int unsigned f_idx(int m);
        return ((pc_v >> 2) & 32'd63) ^ ((m == 1) ? m_ghr[m] : 0);
    endfunction

    function automatic bit f_taken(int m);
        int unsigned b = (pc_v >> 2) & 32'd15;
        return m_bv[m][b] && (m_btag[m][b] == (pc_v >> 6)) && (m_pht[m][f_idx(m)] >= 2);
    endfunction

    function automatic logic [31:0] f_ppc(int m);
        return f_taken(m) ? m_btgt[m][(pc_v >> 2) & 32'd15] : pc_v + 32'd4;
    endfunction

    function automatic bit d_chk(int m);
        return m_rv[m] && br_v && !fl_v;
    endfunction

    function automatic bit d_miss(int m);
        return d_chk(m) && ((m_rtk[m] != rt_v) || (rt_v && (m_rtg[m] != rtg_v)));
    endfunction

    function automatic logic [31:0] d_cpc(int m);
        return rt_v ? rtg_v : m_rpc[m] + 32'd4;
    endfunction

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int unsigned fi = f_idx(m);
            bit          ft = f_taken(m);
            logic [31:0] fp = f_ppc(m);
            bit          dc = d_chk(m);
            bit          dm = d_miss(m);
            if (en_v) begin
                if (dc) begin
                    if (rt_v && m_pht[m][m_ridx[m]] < 3) m_pht[m][m_ridx[m]]++;
                    if (!rt_v && m_pht[m][m_ridx[m]] > 0) m_pht[m][m_ridx[m]]--;
                    m_ghr[m] = ((m_ghr[m] << 1) | (rt_v ? 1 : 0)) & 63;
                    if (rt_v) begin
                        m_bv[m][(m_rpc[m] >> 2) & 32'd15]   = 1;
                        m_btag[m][(m_rpc[m] >> 2) & 32'd15] = m_rpc[m] >> 6;
                        m_btgt[m][(m_rpc[m] >> 2) & 32'd15] = rtg_v;
                    end
                    m_bc[m]++;
                    if (dm) m_mc[m]++;
                end
                m_rv[m]   = !fl_v;
                m_rpc[m]  = pc_v;
                m_ridx[m] = fi;
                m_rtk[m]  = ft;
                m_rtg[m]  = fp;
            end
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            logic [31:0] ppc = m ? b1.predict_pc_o    : b0.predict_pc_o;
            logic        tk  = m ? b1.predict_taken_o : b0.predict_taken_o;
            logic        ms  = m ? b1.miss_o          : b0.miss_o;
            logic [31:0] cpc = m ? b1.correct_pc_o    : b0.correct_pc_o;
            logic [31:0] bc  = m ? b1.branch_cnt_o    : b0.branch_cnt_o;
            logic [31:0] mc  = m ? b1.miss_cnt_o      : b0.miss_cnt_o;
            cmp($sformatf("model_m%0d_predict_pc", m), ppc, f_ppc(m));
            cmp($sformatf("model_m%0d_predict_taken", m), {31'b0, tk}, {31'b0, f_taken(m)});
            cmp($sformatf("model_m%0d_miss", m), {31'b0, ms}, {31'b0, d_miss(m)});
            if (d_miss(m)) cmp($sformatf("model_m%0d_correct_pc", m), cpc, d_cpc(m));
            cmp($sformatf("model_m%0d_branch_cnt", m), bc, m_bc[m]);
            cmp($sformatf("model_m%0d_miss_cnt", m), mc, m_mc[m]);
        end
    endtask

    // Inputs are applied at the falling edge; outputs sampled 1-2 ns later.
    task automatic step();
        #1;
        check_model();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    typedef struct {
        bit en; bit fl; logic [31:0] pc; bit br; bit rt; logic [31:0] rtg;
        logic [31:0] ppc; bit tk; bit chk_d; bit miss; logic [31:0] cpc;
        logic [31:0] bc; logic [31:0] mc;
    } vec_t;

    vec_t tbl[21];
    logic [31:0] pcs  [8];
    logic [31:0] tgts [4];

    initial begin
        rst_i = 1'b0;
        drive(1, 0, 32'h100, 0, 0, 32'h0);

        // en  fl  pc        br rt rtg         ppc        tk chk miss cpc        bc mc   (bimodal instance)
        tbl[0]  = '{1, 0, 32'h100, 0, 0, 32'h000, 32'h104, 0, 1, 0, 32'h000, 0, 0};
        tbl[1]  = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h204, 0, 1, 0, 32'h000, 0, 0};
        tbl[2]  = '{1, 0, 32'h204, 1, 1, 32'h180, 32'h208, 0, 1, 1, 32'h180, 0, 0};
        tbl[3]  = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h180, 1, 1, 0, 32'h000, 1, 1};
        tbl[4]  = '{1, 0, 32'h180, 1, 1, 32'h180, 32'h184, 0, 1, 0, 32'h000, 1, 1};
        tbl[5]  = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h180, 1, 1, 0, 32'h000, 2, 1};
        tbl[6]  = '{1, 0, 32'h200, 1, 1, 32'h180, 32'h180, 1, 1, 0, 32'h000, 2, 1};
        tbl[7]  = '{1, 0, 32'h200, 1, 1, 32'h180, 32'h180, 1, 1, 0, 32'h000, 3, 1};
        tbl[8]  = '{1, 0, 32'h200, 1, 1, 32'h180, 32'h180, 1, 1, 0, 32'h000, 4, 1};
        tbl[9]  = '{1, 0, 32'h200, 1, 0, 32'h180, 32'h180, 1, 1, 1, 32'h204, 5, 1};
        tbl[10] = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h180, 1, 1, 0, 32'h000, 6, 2};
        tbl[11] = '{1, 0, 32'h200, 1, 1, 32'h1C0, 32'h180, 1, 1, 1, 32'h1C0, 6, 2};
        tbl[12] = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h1C0, 1, 1, 0, 32'h000, 7, 3};
        tbl[13] = '{1, 1, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 1, 0, 32'h000, 7, 3};
        tbl[14] = '{1, 0, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 1, 0, 32'h000, 7, 3};
        tbl[15] = '{0, 0, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 0, 0, 32'h000, 7, 3};
        tbl[16] = '{0, 0, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 0, 0, 32'h000, 7, 3};
        tbl[17] = '{0, 0, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 0, 0, 32'h000, 7, 3};
        tbl[18] = '{1, 0, 32'h200, 1, 0, 32'h000, 32'h1C0, 1, 1, 1, 32'h204, 7, 3};
        tbl[19] = '{1, 0, 32'h200, 0, 0, 32'h000, 32'h1C0, 1, 1, 0, 32'h000, 8, 4};
        tbl[20] = '{1, 0, 32'h300, 0, 0, 32'h000, 32'h304, 0, 1, 0, 32'h000, 8, 4};

        pcs  = '{32'h100, 32'h104, 32'h140, 32'h200, 32'h204, 32'h300, 32'h1100, 32'h2140};
        tgts = '{32'h080, 32'h180, 32'h1C0, 32'h280};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].pc, tbl[i].br, tbl[i].rt, tbl[i].rtg);
            #1;
            cmp($sformatf("vec%0d_predict_pc", i), b0.predict_pc_o, tbl[i].ppc);
            cmp($sformatf("vec%0d_predict_taken", i), {31'b0, b0.predict_taken_o}, {31'b0, tbl[i].tk});
            if (tbl[i].chk_d) begin
                cmp($sformatf("vec%0d_miss", i), {31'b0, b0.miss_o}, {31'b0, tbl[i].miss});
                if (tbl[i].miss) cmp($sformatf("vec%0d_correct_pc", i), b0.correct_pc_o, tbl[i].cpc);
            end
            cmp($sformatf("vec%0d_branch_cnt", i), b0.branch_cnt_o, tbl[i].bc);
            cmp($sformatf("vec%0d_miss_cnt", i), b0.miss_cnt_o, tbl[i].mc);
            step();
        end

        // Alternating loop branch at 0x300: gshare must settle within the warm-up window.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            drive(1, 0, 32'h300, c >= 1, ((c - 1) % 2) == 0, 32'h280);
            #1;
            if (c >= 9) cmp($sformatf("gshare_loop_miss_c%0d", c), {31'b0, b1.miss_o}, 32'd0);
            step();
        end
        drive(1, 0, 32'h300, 0, 0, 32'h0);
        #1;
        cmp("gshare_loop_branch_cnt", b1.branch_cnt_o, 32'd20);
        cmp("gshare_loop_miss_cnt_le8", {31'b0, (b1.miss_cnt_o <= 32'd8)}, 32'd1);
        step();

        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  pcs[$urandom_range(0, 7)], $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, tgts[$urandom_range(0, 3)]);
            step();
        end

        // Asynchronous reset mid-operation drops all history immediately.
        drive(1, 0, 32'h200, 1, 1, 32'h180);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        cmp("arst_bim_predict_taken", {31'b0, b0.predict_taken_o}, 32'd0);
        cmp("arst_bim_predict_pc", b0.predict_pc_o, 32'h204);
        cmp("arst_bim_miss", {31'b0, b0.miss_o}, 32'd0);
        cmp("arst_bim_branch_cnt", b0.branch_cnt_o, 32'd0);
        cmp("arst_gsh_predict_taken", {31'b0, b1.predict_taken_o}, 32'd0);
        cmp("arst_gsh_miss_cnt", b1.miss_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 32'h200, c >= 1, 1, 32'h180);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
